dm_port_arbiter: RTL

- Shares the single-port, word-addressed data memory (DM) between two requesters: port 0 (CPU load/store) and port 1 (DMA/debug loader).
- Arbitrates each cycle using round-robin.
- Drives the DM's address, write-data and write-enable inputs, and routes DM read data back to the requester that issued the read.
- Fully pipelined: accepts one access per cycle and keeps accesses in order.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_port_arbiter_rr_arb2.sv | 44 ++++
 rtl/dm_port_arbiter.sv | 87 ++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared constants and types for the data-memory port arbiter.
// Provides default widths, the requester id type, the lock length and a helper
// that returns the opposite requester. Lock support is built only with the
// DM_ARB_LOCK_EN macro.
package dm_arb_pkg;
    localparam int DM_ADDR_W = 7;
    localparam int DM_DATA_W = 32;
    localparam int LOCK_MAX  = 16;
    localparam int LOCK_CW   = $clog2(LOCK_MAX);

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    function automatic req_id_t other(input req_id_t id);
        return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
    endfunction
endpackage

// File: rtl/dm_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker with optional grant lock.
// Ports: req[1:0] requests, ptr current priority holder, lock[1:0] keep-grant
// requests, gnt[1:0] one-hot grant (combinational), nxt_ptr priority for the
// next arbitration. With DM_ARB_LOCK_EN defined it also takes clk/rst (async,
// active-low) and keeps a counter that caps a locked run at LOCK_MAX grants.
module rr_arb2
    import dm_arb_pkg::*;
(
`ifdef DM_ARB_LOCK_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    input  req_id_t    ptr,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output req_id_t    nxt_ptr
);
    req_id_t win;

    // Port 1 wins when it is alone or when it holds priority.
    assign win = req_id_t'(req[1] & (~req[0] | (ptr == REQ_DMA)));
    assign gnt = ~|req ? 2'b00 : (win == REQ_DMA) ? 2'b10 : 2'b01;

`ifdef DM_ARB_LOCK_EN
    logic [LOCK_CW-1:0] cnt;
    logic               hold;

    // The last allowed locked grant hands priority away and clears the run.
    assign hold    = |req && lock[win] && (cnt != LOCK_CW'(LOCK_MAX - 1));
    assign nxt_ptr = ~|req ? ptr : hold ? win : other(win);

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            cnt <= '0;
        else
            cnt <= hold ? cnt + 1'b1 : '0;
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign nxt_ptr     = ~|req ? ptr : other(win);
`endif
endmodule

// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares a single-port word-addressed data memory between
// port 0 (CPU) and port 1 (DMA/debug) with round-robin arbitration.
// Ports: clk, rst (async, active-low); per port rK_req/we/addr/wdata/lock in,
// rK_gnt (combinational), rK_rvalid/rK_rdata out; memory side mem_a/mem_wd/
// mem_wr out (registered), mem_rd in (registered read data from the memory).
// Reads return two cycles after the grant, in grant order; writes are silent.
// Optional macro DM_ARB_LOCK_EN enables the rK_lock keep-grant behaviour.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r0_lock,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic              r1_lock,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [31:0]       mem_a,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rd
);
    req_id_t           rr_ptr, nxt_ptr, owner;
    logic [1:0]        gnt;
    logic              rd_pend, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    rr_arb2 u_arb (
`ifdef DM_ARB_LOCK_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .req     ({r1_req, r0_req}),
        .ptr     (rr_ptr),
        .lock    ({r1_lock, r0_lock}),
        .gnt     (gnt),
        .nxt_ptr (nxt_ptr)
    );

    assign r0_gnt = gnt[0];
    assign r1_gnt = gnt[1];
    assign we     = gnt[1] ? r1_we    : r0_we;
    assign addr   = gnt[1] ? r1_addr  : r0_addr;
    assign wdata  = gnt[1] ? r1_wdata : r0_wdata;

    // mem_a/mem_wd hold on idle cycles so the memory only does a harmless read.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rr_ptr    <= REQ_CPU;
            mem_a     <= '0;
            mem_wd    <= '0;
            mem_wr    <= 1'b0;
            rd_pend   <= 1'b0;
            owner     <= REQ_CPU;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            rr_ptr    <= nxt_ptr;
            mem_wr    <= |gnt & we;
            rd_pend   <= |gnt & ~we;
            if (|gnt) begin
                mem_a  <= {{(32 - ADDR_W){1'b0}}, addr};
                mem_wd <= wdata;
                owner  <= gnt[1] ? REQ_DMA : REQ_CPU;
            end
            r0_rvalid <= rd_pend & (owner == REQ_CPU);
            r1_rvalid <= rd_pend & (owner == REQ_DMA);
        end

    assign r0_rdata = r0_rvalid ? mem_rd : '0;
    assign r1_rdata = r1_rvalid ? mem_rd : '0;
endmodule
